// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers and busy stall.
// Ports: clk, reset (async high), Start, MDUOp, A, B -> Busy, HI, LO, Out.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [3:0]         cnt;
  logic [31:0]        phi;
  logic [31:0]        plo;
  logic               done;
  logic               isop;
  logic               launch;
  logic               ovf;
  logic [31:0]        hcur;
  logic [31:0]        lcur;
  logic [31:0]        nhi;
  logic [31:0]        nlo;
  logic [63:0]        prods;
  logic [63:0]        produ;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  assign Busy = (state == RUN);

  assign sa = A;
  assign sb = B;
  assign sq = sa / sb;
  assign sr = sa % sb;
  assign ovf = (A == 32'h8000_0000) && (B == 32'hffff_ffff);

  assign prods = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign produ = {32'b0, A} * {32'b0, B};

  assign done   = Busy && (cnt == 4'd1);
  assign isop   = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
  // A launch on the completion edge chains directly after the commit.
  assign launch = Start && isop && (!Busy || done);

  // Divide by zero re-latches HI/LO so the later commit is a no-op.
  assign hcur = done ? phi : HI;
  assign lcur = done ? plo : LO;

  always_comb begin
    nhi = hcur;
    nlo = lcur;
    unique case (1'b1)
      (MDUOp == 4'd1): {nhi, nlo} = prods;
      (MDUOp == 4'd2): {nhi, nlo} = produ;
      (MDUOp == 4'd3 && B != 32'd0): begin
        nhi = ovf ? 32'd0 : sr;
        nlo = ovf ? A : sq;
      end
      (MDUOp == 4'd4 && B != 32'd0): begin
        nhi = A % B;
        nlo = A / B;
      end
      default: ;
    endcase
  end

  always_comb begin
    Out = 32'd0;
    if (MDUOp == 4'd7)
      Out = HI;
    else if (MDUOp == 4'd8)
      Out = LO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      if (state == RUN) begin
        cnt <= cnt - 4'd1;
        if (done) begin
          HI    <= phi;
          LO    <= plo;
          state <= IDLE;
        end
      end else if (MDUOp == 4'd5) begin
        HI <= A;
      end else if (MDUOp == 4'd6) begin
        LO <= A;
      end
      if (launch) begin
        phi   <= nhi;
        plo   <= nlo;
        state <= RUN;
        cnt   <= (MDUOp <= 4'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end
    end
  end

endmodule
